// File: rtl/bip_control_unit.sv
// bip_control_unit: registered, multi-cycle BIP instruction decoder.
// Decodes {opcode, operand} into datapath controls through a
// DECODE / EXEC / MEMWAIT / HALT state machine. Data-RAM reads stretch
// over MEM_RD_LAT wait cycles before the accumulator write.
// Optional feature macro: BIP_TRAP_ILLEGAL_EN (illegal opcode traps to HALT
// with a sticky o_illegal instead of executing as a NOP).
module bip_control_unit #(
    parameter int OPCODE_W   = 5,
    parameter int OPERAND_W  = 11,
    parameter int MEM_RD_LAT = 1,
    parameter int ALU_OP_W   = 3
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_instr_valid,
    input  logic [OPCODE_W+OPERAND_W-1:0] i_instruction,
    input  logic                          i_acc_zero,
    input  logic                          i_resume,
    output logic                          o_enable_pc,
    output logic                          o_load_pc,
    output logic [OPERAND_W-1:0]          o_pc_target,
    output logic [1:0]                    o_sel_a,
    output logic                          o_sel_b,
    output logic [ALU_OP_W-1:0]           o_alu_op,
    output logic                          o_write_acc,
    output logic                          o_write_mem,
    output logic                          o_read_mem,
    output logic [OPERAND_W-1:0]          o_operand,
    output logic                          o_halted,
    output logic                          o_illegal
);

    typedef enum logic [1:0] {
        ST_DECODE,
        ST_EXEC,
        ST_MEMWAIT,
        ST_HALT
    } state_e;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HLT  = OPCODE_W'(0),
        OP_STO  = OPCODE_W'(1),
        OP_LD   = OPCODE_W'(2),
        OP_LDI  = OPCODE_W'(3),
        OP_ADD  = OPCODE_W'(4),
        OP_ADDI = OPCODE_W'(5),
        OP_SUB  = OPCODE_W'(6),
        OP_SUBI = OPCODE_W'(7),
        OP_AND  = OPCODE_W'(8),
        OP_ANDI = OPCODE_W'(9),
        OP_OR   = OPCODE_W'(10),
        OP_ORI  = OPCODE_W'(11),
        OP_XOR  = OPCODE_W'(12),
        OP_XORI = OPCODE_W'(13),
        OP_JMP  = OPCODE_W'(14),
        OP_BEQ  = OPCODE_W'(15),
        OP_BNE  = OPCODE_W'(16)
    } opcode_e;

    typedef struct packed {
        logic [1:0]          sel_a;
        logic                sel_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic                write_acc;
        logic                write_mem;
        logic                read_mem;
        logic                branch;
        logic                legal;
    } ctrl_t;

    localparam logic       HAS_WAIT  = (MEM_RD_LAT > 0);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(MEM_RD_LAT - 1) : 4'd0;

    // Static opcode -> control mapping, independent of timing.
    function automatic ctrl_t decode_op(input logic [OPCODE_W-1:0] op);
        ctrl_t c;
        c       = '0;
        c.legal = 1'b1;
        case (op)
            OP_HLT: ;
            OP_STO: c.write_mem = 1'b1;
            OP_LD: begin
                c.write_acc = 1'b1;
                c.read_mem  = 1'b1;
            end
            OP_LDI: begin
                c.sel_a     = 2'd1;
                c.write_acc = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                c.sel_a     = 2'd2;
                c.write_acc = 1'b1;
                c.read_mem  = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
                c.sel_a     = 2'd2;
                c.sel_b     = 1'b1;
                c.write_acc = 1'b1;
            end
            OP_JMP, OP_BEQ, OP_BNE: c.branch = 1'b1;
            default: c.legal = 1'b0;
        endcase
        case (op)
            OP_SUB, OP_SUBI: c.alu_op = ALU_OP_W'(1);
            OP_AND, OP_ANDI: c.alu_op = ALU_OP_W'(2);
            OP_OR,  OP_ORI:  c.alu_op = ALU_OP_W'(3);
            OP_XOR, OP_XORI: c.alu_op = ALU_OP_W'(4);
            default:         c.alu_op = '0;
        endcase
        return c;
    endfunction

    logic [OPCODE_W-1:0]  instr_op;
    logic [OPERAND_W-1:0] instr_opnd;
    ctrl_t                dec_in;
    ctrl_t                dec_q;

    assign instr_op   = i_instruction[OPCODE_W+OPERAND_W-1 -: OPCODE_W];
    assign instr_opnd = i_instruction[OPERAND_W-1:0];

    state_e               state_q, state_d;
    logic [OPCODE_W-1:0]  op_q, op_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 enable_pc_q, enable_pc_d;
    logic                 load_pc_q, load_pc_d;
    logic [OPERAND_W-1:0] pc_target_q, pc_target_d;
    logic [1:0]           sel_a_q, sel_a_d;
    logic                 sel_b_q, sel_b_d;
    logic [ALU_OP_W-1:0]  alu_op_q, alu_op_d;
    logic                 write_acc_q, write_acc_d;
    logic                 write_mem_q, write_mem_d;
    logic                 read_mem_q, read_mem_d;
    logic [OPERAND_W-1:0] operand_q, operand_d;
    logic                 halted_q, halted_d;
    logic                 illegal_q, illegal_d;

    assign dec_in = decode_op(instr_op);
    assign dec_q  = decode_op(op_q);

    // Next state plus the control values that will be visible during it;
    // outputs are registered so they line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        enable_pc_d = 1'b0;
        load_pc_d   = 1'b0;
        pc_target_d = pc_target_q;
        sel_a_d     = '0;
        sel_b_d     = 1'b0;
        alu_op_d    = '0;
        write_acc_d = 1'b0;
        write_mem_d = 1'b0;
        read_mem_d  = 1'b0;
        operand_d   = operand_q;
        halted_d    = 1'b0;
        illegal_d   = 1'b0;

        case (state_q)
            ST_DECODE: begin
                if (i_instr_valid) begin
                    op_d = instr_op;
                    if (instr_op == OP_HLT) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (!dec_in.legal) begin
`ifdef BIP_TRAP_ILLEGAL_EN
                        state_d   = ST_HALT;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
`else
                        state_d     = ST_EXEC;
                        operand_d   = instr_opnd;
                        enable_pc_d = 1'b1;
                        illegal_d   = 1'b1;
`endif
                    end else begin
                        state_d     = ST_EXEC;
                        operand_d   = instr_opnd;
                        sel_a_d     = dec_in.sel_a;
                        sel_b_d     = dec_in.sel_b;
                        alu_op_d    = dec_in.alu_op;
                        write_mem_d = dec_in.write_mem;
                        read_mem_d  = dec_in.read_mem;
                        if (dec_in.read_mem && HAS_WAIT) begin
                            cnt_d = WAIT_INIT;
                        end else begin
                            write_acc_d = dec_in.write_acc;
                            enable_pc_d = 1'b1;
                        end
                        if (dec_in.branch) begin
                            pc_target_d = instr_opnd;
                            if (instr_op == OP_JMP)      load_pc_d = 1'b1;
                            else if (instr_op == OP_BEQ) load_pc_d = i_acc_zero;
                            else                         load_pc_d = ~i_acc_zero;
                        end
                    end
                end
            end
            ST_EXEC: begin
                // Counter is held on entry to MEMWAIT so its first cycle
                // sees MEM_RD_LAT-1; the write lands when it reads zero.
                if (dec_q.read_mem && HAS_WAIT) begin
                    state_d     = ST_MEMWAIT;
                    sel_a_d     = dec_q.sel_a;
                    sel_b_d     = dec_q.sel_b;
                    alu_op_d    = dec_q.alu_op;
                    read_mem_d  = 1'b1;
                    write_acc_d = (cnt_q == 4'd0);
                    enable_pc_d = (cnt_q == 4'd0);
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_MEMWAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DECODE;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                    sel_a_d     = dec_q.sel_a;
                    sel_b_d     = dec_q.sel_b;
                    alu_op_d    = dec_q.alu_op;
                    read_mem_d  = 1'b1;
                    write_acc_d = (cnt_q == 4'd1);
                    enable_pc_d = (cnt_q == 4'd1);
                end
            end
            ST_HALT: begin
                if (i_resume) begin
                    state_d     = ST_EXEC;
                    enable_pc_d = 1'b1;
                end else begin
                    halted_d  = 1'b1;
                    illegal_d = illegal_q;
                end
            end
            default: state_d = ST_DECODE;
        endcase
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_DECODE;
            op_q        <= '0;
            cnt_q       <= '0;
            enable_pc_q <= 1'b0;
            load_pc_q   <= 1'b0;
            pc_target_q <= '0;
            sel_a_q     <= '0;
            sel_b_q     <= 1'b0;
            alu_op_q    <= '0;
            write_acc_q <= 1'b0;
            write_mem_q <= 1'b0;
            read_mem_q  <= 1'b0;
            operand_q   <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            enable_pc_q <= enable_pc_d;
            load_pc_q   <= load_pc_d;
            pc_target_q <= pc_target_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            alu_op_q    <= alu_op_d;
            write_acc_q <= write_acc_d;
            write_mem_q <= write_mem_d;
            read_mem_q  <= read_mem_d;
            operand_q   <= operand_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign o_enable_pc = enable_pc_q;
    assign o_load_pc   = load_pc_q;
    assign o_pc_target = pc_target_q;
    assign o_sel_a     = sel_a_q;
    assign o_sel_b     = sel_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_write_acc = write_acc_q;
    assign o_write_mem = write_mem_q;
    assign o_read_mem  = read_mem_q;
    assign o_operand   = operand_q;
    assign o_halted    = halted_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Testbench for bip_control_unit (MEM_RD_LAT=2): table-driven instruction
// vectors with per-cycle expectations queued by cycle number, plus
// hand-written halt, illegal-opcode and reset sequences.
module tb_bip_control_unit;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [15:0] instr;
    logic        zero;
    logic        resume;
    logic        o_enable_pc, o_load_pc, o_sel_b, o_write_acc, o_write_mem;
    logic        o_read_mem, o_halted, o_illegal;
    logic [10:0] o_pc_target, o_operand;
    logic [1:0]  o_sel_a;
    logic [2:0]  o_alu_op;

    bip_control_unit #(
        .OPCODE_W  (5),
        .OPERAND_W (11),
        .MEM_RD_LAT(LAT),
        .ALU_OP_W  (3)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_instr_valid(valid),
        .i_instruction(instr),
        .i_acc_zero   (zero),
        .i_resume     (resume),
        .o_enable_pc  (o_enable_pc),
        .o_load_pc    (o_load_pc),
        .o_pc_target  (o_pc_target),
        .o_sel_a      (o_sel_a),
        .o_sel_b      (o_sel_b),
        .o_alu_op     (o_alu_op),
        .o_write_acc  (o_write_acc),
        .o_write_mem  (o_write_mem),
        .o_read_mem   (o_read_mem),
        .o_operand    (o_operand),
        .o_halted     (o_halted),
        .o_illegal    (o_illegal)
    );

    typedef struct packed {
        logic        en;
        logic        ldpc;
        logic [10:0] target;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic [2:0]  alu;
        logic        wacc;
        logic        wmem;
        logic        rmem;
        logic [10:0] operand;
        logic        halted;
        logic        illegal;
    } out_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [10:0] opnd;
        logic        zero;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic [2:0]  alu;
        logic        wacc;
        logic        wmem;
        logic        rd;
        logic        ldpc;
        logic        br;
    } vec_t;

    typedef struct {
        int    cyc;
        out_t  exp;
        string nm;
    } sb_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    sb_t         q[$];
    vec_t        vecs[$];
    logic [10:0] exp_operand = '0;
    logic [10:0] exp_target  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic out_t cur();
        out_t a;
        a.en      = o_enable_pc;
        a.ldpc    = o_load_pc;
        a.target  = o_pc_target;
        a.sel_a   = o_sel_a;
        a.sel_b   = o_sel_b;
        a.alu     = o_alu_op;
        a.wacc    = o_write_acc;
        a.wmem    = o_write_mem;
        a.rmem    = o_read_mem;
        a.operand = o_operand;
        a.halted  = o_halted;
        a.illegal = o_illegal;
        return a;
    endfunction

    function automatic out_t idle_exp();
        out_t e;
        e         = '0;
        e.operand = exp_operand;
        e.target  = exp_target;
        return e;
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [10:0] opnd,
                                input logic z, input logic [1:0] sa, input logic sb,
                                input logic [2:0] alu, input logic wacc, input logic wmem,
                                input logic rd, input logic ldpc, input logic br);
        vec_t v;
        v.op = op; v.opnd = opnd; v.zero = z; v.sel_a = sa; v.sel_b = sb;
        v.alu = alu; v.wacc = wacc; v.wmem = wmem; v.rd = rd; v.ldpc = ldpc; v.br = br;
        return v;
    endfunction

    task automatic check(input string nm, input out_t a, input out_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %h required %h (en %b/%b ldpc %b/%b wacc %b/%b rmem %b/%b wmem %b/%b halt %b/%b ill %b/%b opnd %h/%h tgt %h/%h)",
                     nm, cyc, a, e, a.en, e.en, a.ldpc, e.ldpc, a.wacc, e.wacc, a.rmem, e.rmem,
                     a.wmem, e.wmem, a.halted, e.halted, a.illegal, e.illegal,
                     a.operand, e.operand, a.target, e.target);
        end
    endtask

    task automatic push(input int c, input out_t e, input string nm);
        sb_t s;
        s.cyc = c; s.exp = e; s.nm = nm;
        q.push_back(s);
    endtask

    // Scoreboard: compare every queued expectation on the cycle it names.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            sb_t s;
            s = q.pop_front();
            if (s.cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)", s.nm, s.cyc, cyc);
            end else begin
                check(s.nm, cur(), s.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        out_t e;
        int   c;
        c = cyc;
        push(c, idle_exp(), {nm, "_decode"});
        valid = 1'b1;
        instr = {v.op, v.opnd};
        zero  = v.zero;
        exp_operand = v.opnd;
        if (v.br) exp_target = v.opnd;
        e       = idle_exp();
        e.sel_a = v.sel_a;
        e.sel_b = v.sel_b;
        e.alu   = v.alu;
        e.wmem  = v.wmem;
        e.rmem  = v.rd;
        e.ldpc  = v.ldpc;
        if (v.rd) begin
            e.wacc = 1'b0;
            e.en   = 1'b0;
            push(c + 1, e, {nm, "_exec"});
            for (int k = 1; k <= LAT; k++) begin
                e.wacc = (k == LAT);
                e.en   = (k == LAT);
                push(c + 1 + k, e, $sformatf("%s_memwait%0d", nm, k));
            end
        end else begin
            e.wacc = v.wacc;
            e.en   = 1'b1;
            push(c + 1, e, {nm, "_exec"});
        end
        step();
        valid = 1'b0;
        instr = 16'($urandom);
        zero  = 1'($urandom);
        repeat (1 + (v.rd ? LAT : 0)) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        out_t e;
        int   c;
        rst_n  = 1'b0;
        valid  = 1'b0;
        instr  = '0;
        zero   = 1'b0;
        resume = 1'b0;

        //                op     opnd    z  sa  sb alu wacc wmem rd ldpc br
        vecs.push_back(mk(5'h05, 11'h005, 0, 2, 1, 0, 1, 0, 0, 0, 0)); // ADDI
        vecs.push_back(mk(5'h02, 11'h010, 0, 0, 0, 0, 1, 0, 1, 0, 0)); // LD
        vecs.push_back(mk(5'h03, 11'h123, 1, 1, 0, 0, 1, 0, 0, 0, 0)); // LDI
        vecs.push_back(mk(5'h01, 11'h044, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // STO
        vecs.push_back(mk(5'h04, 11'h011, 0, 2, 0, 0, 1, 0, 1, 0, 0)); // ADD
        vecs.push_back(mk(5'h06, 11'h012, 0, 2, 0, 1, 1, 0, 1, 0, 0)); // SUB
        vecs.push_back(mk(5'h07, 11'h7FF, 0, 2, 1, 1, 1, 0, 0, 0, 0)); // SUBI
        vecs.push_back(mk(5'h08, 11'h013, 0, 2, 0, 2, 1, 0, 1, 0, 0)); // AND
        vecs.push_back(mk(5'h09, 11'h0F0, 0, 2, 1, 2, 1, 0, 0, 0, 0)); // ANDI
        vecs.push_back(mk(5'h0A, 11'h014, 0, 2, 0, 3, 1, 0, 1, 0, 0)); // OR
        vecs.push_back(mk(5'h0B, 11'h00F, 0, 2, 1, 3, 1, 0, 0, 0, 0)); // ORI
        vecs.push_back(mk(5'h0C, 11'h015, 0, 2, 0, 4, 1, 0, 1, 0, 0)); // XOR
        vecs.push_back(mk(5'h0D, 11'h555, 0, 2, 1, 4, 1, 0, 0, 0, 0)); // XORI
        vecs.push_back(mk(5'h0E, 11'h3AB, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // JMP
        vecs.push_back(mk(5'h0F, 11'h020, 1, 0, 0, 0, 0, 0, 0, 1, 1)); // BEQ taken
        vecs.push_back(mk(5'h0F, 11'h021, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // BEQ not taken
        vecs.push_back(mk(5'h10, 11'h030, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // BNE taken
        vecs.push_back(mk(5'h10, 11'h031, 1, 0, 0, 0, 0, 0, 0, 0, 1)); // BNE not taken

        #2;
        check("reset_state", cur(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d_op%02h", i, vecs[i].op));

        // i_resume outside HALT has no effect.
        c = cyc;
        push(c, idle_exp(), "resume_ignored_a");
        push(c + 1, idle_exp(), "resume_ignored_b");
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();

        // HLT with a simultaneous resume: HLT wins, then 10 halted cycles
        // ignoring presented instructions, then a single skip cycle.
        c = cyc;
        push(c, idle_exp(), "hlt_decode");
        valid  = 1'b1;
        instr  = {5'h00, 11'h7AB};
        resume = 1'b1;
        e        = idle_exp();
        e.halted = 1'b1;
        for (int k = 1; k <= 10; k++) push(c + k, e, $sformatf("hlt_hold%0d", k));
        e    = idle_exp();
        e.en = 1'b1;
        push(c + 11, e, "hlt_resume_skip");
        push(c + 12, idle_exp(), "hlt_back_to_decode");
        step();
        resume = 1'b0;
        instr  = {5'h05, 11'h001};
        repeat (9) step();
        valid  = 1'b0;
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();

        // Illegal opcode 0x1F.
        c = cyc;
        push(c, idle_exp(), "illegal_decode");
        valid = 1'b1;
        instr = {5'h1F, 11'h0AA};
`ifdef BIP_TRAP_ILLEGAL_EN
        e         = idle_exp();
        e.halted  = 1'b1;
        e.illegal = 1'b1;
        for (int k = 1; k <= 4; k++) push(c + k, e, $sformatf("illegal_trap%0d", k));
        e    = idle_exp();
        e.en = 1'b1;
        push(c + 5, e, "illegal_resume_skip");
        push(c + 6, idle_exp(), "illegal_back_to_decode");
        step();
        valid = 1'b0;
        repeat (3) step();
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
`else
        exp_operand = 11'h0AA;
        e         = idle_exp();
        e.en      = 1'b1;
        e.illegal = 1'b1;
        push(c + 1, e, "illegal_nop");
        push(c + 2, idle_exp(), "illegal_after");
        step();
        valid = 1'b0;
        step();
`endif

        // Reset asserted in the middle of a MEMWAIT.
        c = cyc;
        push(c, idle_exp(), "rst_ld_decode");
        valid = 1'b1;
        instr = {5'h02, 11'h055};
        exp_operand = 11'h055;
        e      = idle_exp();
        e.rmem = 1'b1;
        push(c + 1, e, "rst_ld_exec");
        step();
        valid = 1'b0;
        step();
        check("rst_in_memwait", cur(), e);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", cur(), '0);
        exp_operand = '0;
        exp_target  = '0;
        step();
        check("rst_held", cur(), '0);
        rst_n = 1'b1;
        c = cyc;
        push(c, idle_exp(), "rst_release_a");
        push(c + 1, idle_exp(), "rst_release_b");
        step();
        step();
        run_vec(vecs[0], "post_reset_addi");

        step();
        step();
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
